text_buffer_responder: RTL and testbench

- Memory-side responder for the Text_Generator character/attribute read interface.
- Answers every read strobe with data exactly 3 cycles later. Absorbs host writes through a small FIFO and commits them only on cycles with no video read.
- After reset, clears the whole buffer to a fill word so the screen comes up blank.
- Sits between host/debug logic and Text_Generator in the video pipeline.

---
 rtl/text_buffer_responder.sv | 174 +++++++++++++++++
 tb/tb_text_buffer_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_responder.sv
// text_buffer_responder
//   Memory-side responder for the Text_Generator character/attribute read
//   interface. Every video read strobe is answered exactly three cycles later.
//   Host writes are queued in a small FIFO and committed only on cycles where
//   no video read occupies the RAM port. After reset the whole buffer is
//   overwritten with FILL so the screen comes up blank.
//
//   The release of rst_ni is expected to be synchronous to clk_i. Its
//   assertion may be asynchronous.
//
// Ports
//   clk_i        pixel clock
//   rst_ni       asynchronous active-low reset
//   rd_addr_i    video read word address (bits above ADDR_W must be zero)
//   rd_strobe_i  video read request, may be high every cycle
//   rd_data_o    read data, valid 3 cycles after its strobe, held until replaced
//   wr_valid_i   host write request
//   wr_ready_o   host write accepted when valid && ready
//   wr_addr_i    host write word address
//   wr_data_i    host write data
//   wr_be_i      byte enables, bit n covers bits [8n+7:8n]
//   busy_o       high while the post-reset clear runs
//   overflow_o   sticky flag: a host write to an out-of-range address was dropped
module text_buffer_responder #(
  parameter int                ADDR_W      = 11,
  parameter int                DATA_W      = 16,
  parameter logic [DATA_W-1:0] FILL        = 16'h0020,
  parameter int                WFIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [15:0]         rd_addr_i,
  input  logic                rd_strobe_i,
  output logic [DATA_W-1:0]   rd_data_o,
  input  logic                wr_valid_i,
  output logic                wr_ready_o,
  input  logic [15:0]         wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic [DATA_W/8-1:0] wr_be_i,
  output logic                busy_o,
  output logic                overflow_o
);

  localparam int BE_W        = DATA_W / 8;
  localparam int PTR_W       = $clog2(WFIFO_DEPTH);
  localparam int DEPTH_WORDS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]    PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic {CLEAR, RUN} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_cnt_q;
  logic                busy_q;
  logic                overflow_q;

  // Read pipeline: S1 address/flags, S2 RAM output, S3 output register
  logic                s1_valid_q, s1_fill_q, s1_oor_q;
  logic [ADDR_W-1:0]   s1_addr_q;
  logic                s2_valid_q, s2_fill_q, s2_oor_q;
  logic [DATA_W-1:0]   s2_data_q;
  logic [DATA_W-1:0]   rd_data_q;

  logic [DATA_W-1:0]   mem_q [DEPTH_WORDS];

  // Write FIFO storage; pointers carry one extra bit to tell full from empty
  logic [15:0]         fifo_addr_q [WFIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [WFIFO_DEPTH];
  logic [BE_W-1:0]     fifo_be_q   [WFIFO_DEPTH];
  logic [PTR_W:0]      wptr_q, rptr_q, wptr_d, rptr_d;

  logic                rd_oor, fifo_empty, fifo_full, wr_ready, push, commit;
  logic [PTR_W-1:0]    head_idx;
  logic [15:0]         head_addr;
  logic                head_oor;

  assign rd_oor     = |(rd_addr_i >> ADDR_W);
  assign fifo_empty = (wptr_q == rptr_q);
  assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                      (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
  // Ready is derived from registered state, so a pop in the same cycle as a
  // full FIFO does not open a slot until the following cycle.
  assign wr_ready   = (state_q == RUN) && !fifo_full;
  assign push       = wr_valid_i && wr_ready;
  // The RAM has one port: a read sitting in S1 owns it this cycle.
  assign commit     = (state_q == RUN) && !s1_valid_q && !fifo_empty;
  assign head_idx   = rptr_q[PTR_W-1:0];
  assign head_addr  = fifo_addr_q[head_idx];
  assign head_oor   = |(head_addr >> ADDR_W);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push)   wptr_d = wptr_q + PTR_ONE;
    if (commit) rptr_d = rptr_q + PTR_ONE;
  end

  // Control FSM, read pipeline flags, FIFO pointers and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CLEAR;
      clr_cnt_q  <= '0;
      busy_q     <= 1'b1;
      overflow_q <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_fill_q  <= 1'b0;
      s1_oor_q   <= 1'b0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_fill_q  <= 1'b0;
      s2_oor_q   <= 1'b0;
      rd_data_q  <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + CNT_ONE;
          if (clr_cnt_q == {ADDR_W{1'b1}}) begin
            state_q <= RUN;
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (commit && head_oor) overflow_q <= 1'b1;
        end
        default: state_q <= CLEAR;
      endcase

      // Reads issued during CLEAR return FILL whatever their address
      s1_valid_q <= rd_strobe_i;
      s1_fill_q  <= (state_q == CLEAR);
      s1_oor_q   <= rd_oor;
      s1_addr_q  <= rd_addr_i[ADDR_W-1:0];

      s2_valid_q <= s1_valid_q;
      s2_fill_q  <= s1_fill_q;
      s2_oor_q   <= s1_oor_q;

      if (s2_valid_q) begin
        if (s2_fill_q)     rd_data_q <= FILL;
        else if (s2_oor_q) rd_data_q <= '0;
        else               rd_data_q <= s2_data_q;
      end

      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Single-port RAM with byte writes plus FIFO storage; contents are not reset
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      mem_q[clr_cnt_q] <= FILL;
    end else if (commit && !head_oor) begin
      for (int b = 0; b < BE_W; b++) begin
        if (fifo_be_q[head_idx][b])
          mem_q[head_addr[ADDR_W-1:0]][8*b +: 8] <= fifo_data_q[head_idx][8*b +: 8];
      end
    end
    if (s1_valid_q && !s1_fill_q) s2_data_q <= mem_q[s1_addr_q];
    if (push) begin
      fifo_addr_q[wptr_q[PTR_W-1:0]] <= wr_addr_i;
      fifo_data_q[wptr_q[PTR_W-1:0]] <= wr_data_i;
      fifo_be_q[wptr_q[PTR_W-1:0]]   <= wr_be_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign wr_ready_o = wr_ready;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_text_buffer_responder.sv
// tb_text_buffer_responder
//   Self-checking bench for text_buffer_responder with a 16-word buffer.
//   A behavioural model (array memory, queue of pending writes, queue of
//   pending read results) predicts every output each cycle; a few literal
//   expectations pin down the headline behaviours.
module tb_text_buffer_responder;

  localparam int AW    = 4;
  localparam int DW    = 16;
  localparam int FD    = 4;
  localparam int WORDS = 1 << AW;
  localparam logic [15:0] FILLV = 16'h0020;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   rdAddr = '0;
  logic          rdStrobe = 1'b0;
  logic [DW-1:0] rdData;
  logic          wrValid = 1'b0;
  logic          wrReady;
  logic [15:0]   wrAddr = '0;
  logic [DW-1:0] wrData = '0;
  logic [1:0]    wrBe = '0;
  logic          busy;
  logic          overflow;

  int tests = 0;
  int failed = 0;

  text_buffer_responder #(
    .ADDR_W(AW), .DATA_W(DW), .FILL(FILLV), .WFIFO_DEPTH(FD)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rd_addr_i(rdAddr), .rd_strobe_i(rdStrobe), .rd_data_o(rdData),
    .wr_valid_i(wrValid), .wr_ready_o(wrReady), .wr_addr_i(wrAddr),
    .wr_data_i(wrData), .wr_be_i(wrBe),
    .busy_o(busy), .overflow_o(overflow)
  );

  // 10 ns pixel clock stand-in
  always #5 clk = ~clk;

  // Behavioural model state
  typedef struct { logic [15:0] addr; logic [15:0] data; logic [1:0] be; } wr_t;
  typedef struct { int due; logic [15:0] val; } rd_t;

  logic [15:0] mMem [WORDS];
  wr_t         mFifo[$];
  rd_t         mPend[$];
  int          mCyc = 0;
  bit          mClear = 1'b1;
  int          mClrCnt = 0;
  bit          mOvf = 1'b0;
  logic [15:0] mRd = '0;
  bit          pStb = 1'b0, pFill = 1'b0, pOor = 1'b0;
  logic [15:0] pAddr = '0;
  bit          wasClear, rdyBefore;
  wr_t         head;
  logic [15:0] rv;

  // Compare helper: one comparison, one FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model advance: reads are answered from memory as it stands one edge after
  // capture, writes commit only on edges with no read captured the edge before,
  // and the clear sweep writes FILL one word per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mClear = 1'b1; mClrCnt = 0; mOvf = 1'b0; mRd = '0; pStb = 1'b0; mCyc = 0;
      mFifo.delete(); mPend.delete();
    end else begin
      mCyc++;
      wasClear  = mClear;
      rdyBefore = !mClear && (mFifo.size() < FD);
      while (mPend.size() > 0 && mPend[0].due == mCyc) begin
        mRd = mPend[0].val;
        void'(mPend.pop_front());
      end
      if (pStb) begin
        if (pFill)     rv = FILLV;
        else if (pOor) rv = 16'h0000;
        else           rv = mMem[pAddr[AW-1:0]];
        mPend.push_back('{mCyc + 1, rv});
      end
      if (!wasClear && !pStb && mFifo.size() > 0) begin
        head = mFifo.pop_front();
        if (head.addr >= WORDS) mOvf = 1'b1;
        else
          for (int b = 0; b < 2; b++)
            if (head.be[b]) mMem[head.addr[AW-1:0]][8*b +: 8] = head.data[8*b +: 8];
      end
      if (wasClear) begin
        mMem[mClrCnt] = FILLV;
        if (mClrCnt == WORDS - 1) mClear = 1'b0;
        else mClrCnt++;
      end
      if (wrValid && rdyBefore) mFifo.push_back('{wrAddr, wrData, wrBe});
      pStb  = rdStrobe;
      pFill = wasClear;
      pOor  = (rdAddr >= WORDS);
      pAddr = rdAddr;
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("rd_data", {16'h0, rdData}, {16'h0, mRd});
      checkOutput("busy", {31'h0, busy}, {31'h0, mClear});
      checkOutput("wr_ready", {31'h0, wrReady}, {31'h0, (!mClear && mFifo.size() < FD)});
      checkOutput("overflow", {31'h0, overflow}, {31'h0, mOvf});
    end
  end

  bit lastAcc;

  // Drive one cycle of inputs (called at a falling edge), note whether the
  // write handshake completes, and return at the next falling edge.
  task automatic applyStimulus(input bit stb, input logic [15:0] ra, input bit wv,
                               input logic [15:0] wa, input logic [15:0] wd,
                               input logic [1:0] be);
    rdStrobe = stb; rdAddr = ra; wrValid = wv; wrAddr = wa; wrData = wd; wrBe = be;
    lastAcc  = wv && wrReady;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 2'b00);
  endtask

  task automatic readAll();
    for (int i = 0; i < WORDS; i++) applyStimulus(1'b1, 16'(i), 1'b0, 16'h0, 16'h0, 2'b00);
    idle(3);
  endtask

  // Run through the clear sweep with random reads; returns edges until busy drops
  task automatic runClear(output int n);
    n = 0;
    do begin
      applyStimulus(1'($urandom_range(0, 1)), 16'($urandom), 1'b0, 16'h0, 16'h0, 2'b00);
      n++;
    end while (busy && n < 100);
  endtask

  int n, acc;
  logic [15:0] sA [6];
  logic [15:0] sD [6];
  logic [1:0]  sB [6];
  bit          rStb, rWv;
  logic [15:0] rRa, rWa;

  initial begin
    for (int i = 0; i < WORDS; i++) mMem[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rd_data", {16'h0, rdData}, 32'h0);
    checkOutput("reset_busy", {31'h0, busy}, 32'h1);
    checkOutput("reset_ready", {31'h0, wrReady}, 32'h0);
    checkOutput("reset_overflow", {31'h0, overflow}, 32'h0);

    // Clear sweep length and blank contents
    rst_n = 1'b1;
    runClear(n);
    checkOutput("busy_cycles", n, 16);
    readAll();
    checkOutput("fill_read", {16'h0, rdData}, {16'h0, FILLV});

    // Single write, then read with exact latency
    applyStimulus(1'b0, 16'h0, 1'b1, 16'd5, 16'hABCD, 2'b11);
    checkOutput("first_write_accepted", {31'h0, lastAcc}, 32'h1);
    idle(2);
    applyStimulus(1'b1, 16'd5, 1'b0, 16'h0, 16'h0, 2'b00);
    checkOutput("rd_plus1", {16'h0, rdData}, 32'h0020);
    idle(1);
    checkOutput("rd_plus2", {16'h0, rdData}, 32'h0020);
    idle(1);
    checkOutput("rd_plus3", {16'h0, rdData}, 32'hABCD);

    // Byte-enabled partial write
    applyStimulus(1'b0, 16'h0, 1'b1, 16'd5, 16'h1234, 2'b01);
    idle(2);
    applyStimulus(1'b1, 16'd5, 1'b0, 16'h0, 16'h0, 2'b00);
    idle(2);
    checkOutput("byte_enable", {16'h0, rdData}, 32'hAB34);

    // Continuous strobes starve commits and fill the FIFO
    for (int i = 0; i < 6; i++) begin
      sA[i] = 16'($urandom_range(0, WORDS - 1));
      sD[i] = 16'($urandom);
      sB[i] = 2'($urandom_range(1, 3));
    end
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 16'($urandom_range(0, WORDS - 1)), acc < 6,
                    sA[acc % 6], sD[acc % 6], sB[acc % 6]);
      if (lastAcc) acc++;
    end
    checkOutput("stall_accepted", acc, 4);
    checkOutput("stall_ready", {31'h0, wrReady}, 32'h0);
    idle(1);
    checkOutput("stall_ready_last_read", {31'h0, wrReady}, 32'h0);
    idle(1);
    checkOutput("ready_after_commit", {31'h0, wrReady}, 32'h1);
    idle(4);
    readAll();

    // Out-of-range write is accepted, dropped, and flagged
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h8000, 16'hDEAD, 2'b11);
    checkOutput("oor_write_accepted", {31'h0, lastAcc}, 32'h1);
    idle(1);
    checkOutput("overflow_set", {31'h0, overflow}, 32'h1);
    applyStimulus(1'b1, 16'h8000, 1'b0, 16'h0, 16'h0, 2'b00);
    idle(2);
    checkOutput("oor_read_zero", {16'h0, rdData}, 32'h0);
    readAll();

    // Randomised traffic checked by the model
    for (int k = 0; k < 400; k++) begin
      rStb = 1'($urandom_range(0, 1));
      rRa  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(WORDS, 65535))
                                          : 16'($urandom_range(0, WORDS - 1));
      rWv  = ($urandom_range(0, 2) == 0);
      rWa  = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(WORDS, 65535))
                                           : 16'($urandom_range(0, WORDS - 1));
      applyStimulus(rStb, rRa, rWv, rWa, 16'($urandom), 2'($urandom));
    end
    idle(6);
    readAll();
    checkOutput("overflow_sticky", {31'h0, overflow}, 32'h1);
    idle(6);

    // Reset with queued writes and a read in flight
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 16'(k), 1'b1, 16'd7, 16'h5555 + 16'(k), 2'b11);
    applyStimulus(1'b1, 16'd7, 1'b0, 16'h0, 16'h0, 2'b00);
    #1 rst_n = 1'b0;
    rdStrobe = 1'b0; wrValid = 1'b0;
    #1;
    checkOutput("midreset_rd_data", {16'h0, rdData}, 32'h0);
    checkOutput("midreset_busy", {31'h0, busy}, 32'h1);
    checkOutput("midreset_ready", {31'h0, wrReady}, 32'h0);
    checkOutput("midreset_overflow", {31'h0, overflow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    runClear(n);
    checkOutput("busy_cycles_after_reset", n, 16);
    readAll();
    applyStimulus(1'b1, 16'd7, 1'b0, 16'h0, 16'h0, 2'b00);
    idle(2);
    checkOutput("queued_write_dropped", {16'h0, rdData}, {16'h0, FILLV});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
